// File: rtl/useq_clken_ctrl.sv
// Purpose : microsequencer clock-enable / reset controller (INIT, HALT, RUN, STEP, WAIT).
// Latency : Moore outputs decoded from registered state; nxm is a registered one-cycle pulse.
// Backpressure: memory wait stalls clken until memACK or the TIMEOUT abort, then resumes.
//
// Ports:
//   clk      - system clock, all state changes on rising edge
//   rst      - synchronous active-low reset
//   run      - console run request (level)
//   halt     - console halt request (level)
//   step     - single-step request (one-cycle pulse)
//   cromHALT - halt bit of the current microword
//   memREQ   - microword requests a memory/bus cycle
//   memACK   - bus acknowledge (one-cycle pulse)
//   useqRST  - active-high microsequencer reset (INIT only)
//   clken    - microsequencer clock enable (INIT, RUN, STEP)
//   halted   - high while in HALT
//   nxm      - one-cycle pulse after a memory-wait timeout
//   state    - INIT=0, HALT=1, RUN=2, STEP=3, WAIT=4
module useq_clken_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       halt,
  input  logic       step,
  input  logic       cromHALT,
  input  logic       memREQ,
  input  logic       memACK,
  output logic       useqRST,
  output logic       clken,
  output logic       halted,
  output logic       nxm,
  output logic [2:0] state
);

  localparam int IW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LOAD = IW'(RST_CYCLES - 1);
  localparam logic [7:0]    WAIT_MAX  = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_HALT = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          resume_run_q, resume_run_d;  // 1: resume RUN, 0: resume HALT
  logic          nxm_q, nxm_d;
  state_t        resume_state;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    resume_run_d = resume_run_q;
    nxm_d        = 1'b0;
    resume_state = resume_run_q ? S_RUN : S_HALT;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == '0) begin
          state_d = S_HALT;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end

      // halt dominates, so run/step requested while halted are dropped
      S_HALT: begin
        if (!halt) begin
          if (run) begin
            state_d = S_RUN;
          end else if (step) begin
            state_d = S_STEP;
          end
        end
      end

      // memREQ wins over cromHALT; the microword re-asserts cromHALT after the wait
      S_RUN: begin
        if (memREQ) begin
          state_d      = S_WAIT;
          resume_run_d = 1'b1;
          wait_cnt_d   = '0;
        end else if (halt || cromHALT) begin
          state_d = S_HALT;
        end
      end

      S_STEP: begin
        if (memREQ) begin
          state_d      = S_WAIT;
          resume_run_d = 1'b0;
          wait_cnt_d   = '0;
        end else begin
          state_d = S_HALT;
        end
      end

      // acknowledge beats a coincident timeout, so nxm only fires without memACK
      S_WAIT: begin
        if (memACK) begin
          state_d = resume_state;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = resume_state;
          nxm_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = S_INIT;
        init_cnt_d = INIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      init_cnt_q   <= INIT_LOAD;
      wait_cnt_q   <= '0;
      resume_run_q <= 1'b0;
      nxm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      resume_run_q <= resume_run_d;
      nxm_q        <= nxm_d;
    end
  end

  assign useqRST = (state_q == S_INIT);
  assign clken   = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_STEP);
  assign halted  = (state_q == S_HALT);
  assign nxm     = nxm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_useq_clken_ctrl.sv
// Purpose : self-checking bench for useq_clken_ctrl (vector table, corner sequences, random vs model).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a (bench drives memACK directly).
module tb_useq_clken_ctrl;

  localparam int RC = 4;
  localparam int TO = 63;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_HALT = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       halt = 1'b0;
  logic       step = 1'b0;
  logic       cromHALT = 1'b0;
  logic       memREQ = 1'b0;
  logic       memACK = 1'b0;
  logic       useqRST;
  logic       clken;
  logic       halted;
  logic       nxm;
  logic [2:0] state;

  useq_clken_ctrl #(.RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .halt     (halt),
    .step     (step),
    .cromHALT (cromHALT),
    .memREQ   (memREQ),
    .memACK   (memACK),
    .useqRST  (useqRST),
    .clken    (clken),
    .halted   (halted),
    .nxm      (nxm),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // input order: {rst, run, halt, step, cromHALT, memREQ, memACK}
  task automatic set_in(input logic [6:0] v);
    {rst, run, halt, step, cromHALT, memREQ, memACK} = v;
  endtask

  function automatic logic [31:0] outs_now();
    return {25'd0, state, useqRST, clken, halted, nxm};
  endfunction

  task automatic reset_to_halt;
    set_in(7'b0000000);
    tick;
    set_in(7'b1000000);
    repeat (RC) tick;
    check("reset_reaches_halt", {29'd0, state}, {29'd0, ST_HALT});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0] in;    // {rst,run,halt,step,cromHALT,memREQ,memACK}
    logic [2:0] st;    // expected state after the edge
    logic [3:0] outs;  // expected {useqRST,clken,halted,nxm}
  } vec_t;

  vec_t vecs[24];

  // ---------------- reference model ----------------
  // mode numbers follow the state encoding; counters count cycles, not states
  int m_mode;
  int m_init_left;   // INIT cycles still to spend, including the current one
  int m_waited;      // WAIT cycles already spent, including the current one
  bit m_resume_run;
  bit m_nxm;

  task automatic model_edge;
    bit pulse;
    pulse = 1'b0;
    if (!rst) begin
      m_mode = 0; m_init_left = RC; m_waited = 0; m_resume_run = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          m_init_left = m_init_left - 1;
          if (m_init_left == 0) m_mode = 1;
        end
        1: if (!halt && run) m_mode = 2;
           else if (!halt && step) m_mode = 3;
        2: if (memREQ) begin m_resume_run = 1'b1; m_waited = 0; m_mode = 4; end
           else if (halt || cromHALT) m_mode = 1;
        3: if (memREQ) begin m_resume_run = 1'b0; m_waited = 0; m_mode = 4; end
           else m_mode = 1;
        default: begin
          m_waited = m_waited + 1;
          if (memACK) m_mode = m_resume_run ? 2 : 1;
          else if (m_waited == TO + 1) begin
            pulse = 1'b1;
            m_mode = m_resume_run ? 2 : 1;
          end
        end
      endcase
    end
    m_nxm = pulse;
  endtask

  function automatic logic [31:0] model_outs();
    logic [2:0] s;
    logic u, c, h;
    s = 3'(m_mode);
    u = (m_mode == 0);
    c = (m_mode == 0) || (m_mode == 2) || (m_mode == 3);
    h = (m_mode == 1);
    return {25'd0, s, u, c, h, m_nxm};
  endfunction

  initial begin
    int zc;
    bit nseen;
    int cnt;

    vecs[0]  = '{7'b0000000, ST_INIT, 4'b1100};
    vecs[1]  = '{7'b0000000, ST_INIT, 4'b1100};
    vecs[2]  = '{7'b1100000, ST_INIT, 4'b1100};
    vecs[3]  = '{7'b1100000, ST_INIT, 4'b1100};
    vecs[4]  = '{7'b1100000, ST_INIT, 4'b1100};
    vecs[5]  = '{7'b1100000, ST_HALT, 4'b0010};  // first post-reset state is HALT even with run
    vecs[6]  = '{7'b1100000, ST_RUN,  4'b0100};
    vecs[7]  = '{7'b1111100, ST_HALT, 4'b0010};
    vecs[8]  = '{7'b1110000, ST_HALT, 4'b0010};
    vecs[9]  = '{7'b1011000, ST_HALT, 4'b0010};  // step under halt ignored
    vecs[10] = '{7'b1100000, ST_RUN,  4'b0100};
    vecs[11] = '{7'b1000100, ST_HALT, 4'b0010};
    vecs[12] = '{7'b1001000, ST_STEP, 4'b0100};
    vecs[13] = '{7'b1000000, ST_HALT, 4'b0010};
    vecs[14] = '{7'b1000001, ST_HALT, 4'b0010};  // stray memACK in HALT
    vecs[15] = '{7'b1001000, ST_STEP, 4'b0100};
    vecs[16] = '{7'b1000110, ST_WAIT, 4'b0000};
    vecs[17] = '{7'b1000001, ST_HALT, 4'b0010};
    vecs[18] = '{7'b1100000, ST_RUN,  4'b0100};
    vecs[19] = '{7'b1100110, ST_WAIT, 4'b0000};
    vecs[20] = '{7'b1110000, ST_WAIT, 4'b0000};  // halt ignored in WAIT
    vecs[21] = '{7'b1000001, ST_RUN,  4'b0100};
    vecs[22] = '{7'b1001000, ST_RUN,  4'b0100};  // step outside HALT ignored
    vecs[23] = '{7'b1000000, ST_RUN,  4'b0100};

    #2;
    for (int i = 0; i < 24; i++) begin
      set_in(vecs[i].in);
      tick;
      check($sformatf("vec_%0d", i), outs_now(), {25'd0, vecs[i].st, vecs[i].outs});
    end

    // memory wait acknowledged on the sixth WAIT cycle
    reset_to_halt;
    set_in(7'b1100000); tick;
    set_in(7'b1100010); tick;
    set_in(7'b1100000);
    zc = 0; nseen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      memACK = (k == 5);
      if (!clken) zc++;
      tick;
      nseen = nseen | nxm;
    end
    memACK = 1'b0;
    check("ack_wait_clken_low_cycles", zc, 6);
    check("ack_wait_resume_run", {29'd0, state}, {29'd0, ST_RUN});
    check("ack_wait_no_nxm", {31'd0, nseen}, 32'd0);

    // STEP into WAIT with no acknowledge -> timeout abort
    reset_to_halt;
    set_in(7'b1001000); tick;
    set_in(7'b1000010); tick;
    set_in(7'b1000000);
    cnt = 0;
    while (state == ST_WAIT && cnt < 300) begin
      cnt++;
      tick;
    end
    check("timeout_wait_cycles", cnt, 64);
    check("timeout_nxm_pulse", {31'd0, nxm}, 32'd1);
    check("timeout_resume_halt", {29'd0, state}, {29'd0, ST_HALT});
    tick;
    check("timeout_nxm_one_cycle", {31'd0, nxm}, 32'd0);

    // memACK on the timeout cycle wins
    set_in(7'b1001000); tick;
    set_in(7'b1000010); tick;
    set_in(7'b1000000);
    repeat (TO) tick;
    check("ack_vs_timeout_still_wait", {29'd0, state}, {29'd0, ST_WAIT});
    memACK = 1'b1; tick; memACK = 1'b0;
    check("ack_vs_timeout_state", {29'd0, state}, {29'd0, ST_HALT});
    check("ack_vs_timeout_no_nxm", {31'd0, nxm}, 32'd0);

    // reset in the middle of WAIT, then a late acknowledge
    reset_to_halt;
    set_in(7'b1100000); tick;
    set_in(7'b1100010); tick;
    set_in(7'b1100000);
    repeat (9) tick;
    check("mid_wait_before_reset", {29'd0, state}, {29'd0, ST_WAIT});
    set_in(7'b0100000); tick;
    check("mid_wait_reset_outs", outs_now(), {25'd0, ST_INIT, 4'b1100});
    set_in(7'b1100001);
    nseen = 1'b0;
    repeat (RC - 1) begin
      tick;
      nseen = nseen | nxm;
    end
    check("late_ack_still_init", {29'd0, state}, {29'd0, ST_INIT});
    tick;
    check("late_ack_then_halt", outs_now(), {25'd0, ST_HALT, 4'b0010});
    check("late_ack_no_nxm", {31'd0, nseen}, 32'd0);
    set_in(7'b1100000);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst      = (c < 2) ? 1'b0 : ($urandom_range(149) != 0);
      run      = 1'($urandom_range(1));
      halt     = ($urandom_range(4) == 0);
      step     = ($urandom_range(3) == 0);
      cromHALT = ($urandom_range(7) == 0);
      memREQ   = ($urandom_range(3) == 0);
      memACK   = ($urandom_range(39) == 0);
      model_edge();
      tick;
      check($sformatf("rand_cycle_%0d", c), outs_now(), model_outs());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/useq_clken_ctrl.md
USEQ_CLKEN_CTRL -- requirements
Module: useq_clken_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, default 4, number of cycles the microsequencer reset is held after init.
REQ-002 Parameter: TIMEOUT, default 63, maximum memory-wait cycles before non-existent-memory abort; range 1..255.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: run  input  1  console run request, level.
REQ-006 Port: halt  input  1  console halt request, level.
REQ-007 Port: step  input  1  single-step request, one-cycle pulse.
REQ-008 Port: cromHALT  input  1  microword halt bit of the current microinstruction.
REQ-009 Port: memREQ  input  1  microword requests a memory/bus cycle.
REQ-010 Port: memACK  input  1  bus acknowledge, one-cycle pulse.
REQ-011 Port: useqRST  output  1  active-high reset to the microsequencer.
REQ-012 Port: clken  output  1  microsequencer clock enable.
REQ-013 Port: halted  output  1  high while in HALT.
REQ-014 Port: nxm  output  1  one-cycle pulse on memory-wait timeout.
REQ-015 Port: state  output  3  current state encoding: INIT=0, HALT=1, RUN=2, STEP=3, WAIT=4.

Function
REQ-016 The block SHALL be a Moore FSM with states INIT, HALT, RUN, STEP, WAIT; outputs derive from registered state only.
REQ-017 INIT SHALL drive useqRST=1, clken=1 for RST_CYCLES cycles (counter from RST_CYCLES-1 to 0), then go to HALT; useqRST negates synchronously on the HALT entry edge.
REQ-018 HALT SHALL drive clken=0, halted=1; halt=1 keeps HALT; else run=1 -> RUN; else step=1 -> STEP.
REQ-019 RUN SHALL drive clken=1; exit priority: memREQ=1 -> WAIT (resume=RUN); else halt=1 or cromHALT=1 -> HALT; else stay.
REQ-020 STEP SHALL drive clken=1 for exactly one cycle; memREQ=1 -> WAIT (resume=HALT); else -> HALT.
REQ-021 WAIT SHALL drive clken=0; memACK=1 -> resume state next cycle; halt and run ignored in WAIT.
REQ-022 WAIT SHALL count cycles from 0; on count reaching TIMEOUT without memACK, pulse nxm=1 for one cycle and go to resume state; counter clears on every WAIT entry.
REQ-023 memACK and timeout on same cycle: memACK wins, nxm stays 0.
REQ-024 memACK outside WAIT, step outside HALT, and run/step while halt=1 SHALL be ignored.
REQ-025 memREQ, cromHALT sampled only in cycles with clken=1 (RUN, STEP); memREQ takes priority over cromHALT; a RUN-state cycle with both returns to RUN after WAIT, cromHALT must be reasserted by the microword.
REQ-026 Resume register SHALL be 1 bit (RUN/HALT), written only on WAIT entry.
REQ-027 nxm SHALL be registered, never asserted except on the cycle following timeout.

Reset
REQ-028 rst=0 at any clock edge, in any state including mid-WAIT, SHALL force INIT, INIT counter=RST_CYCLES-1, wait counter=0, resume=HALT, nxm=0.
REQ-029 During rst=0 and INIT: useqRST=1, clken=1, halted=0, state=0.
REQ-030 Reset values after release: first non-INIT state is always HALT regardless of run.

Verification
REQ-031 Release rst with run=1 -> useqRST=1, clken=1 for exactly 4 cycles, then one HALT cycle (halted=1, clken=0), then RUN with clken=1.
REQ-032 In HALT, pulse step with memREQ=0 -> exactly one clken=1 cycle, then halted=1.
REQ-033 In RUN, memREQ=1; memACK after 5 cycles -> clken=0 for 6 cycles (WAIT), then RUN, nxm never asserted.
REQ-034 In STEP, memREQ=1, no memACK -> WAIT for 64 cycles, nxm=1 for one cycle, state=HALT.
REQ-035 In RUN, halt=1 and cromHALT=1 together with run=1 -> HALT next cycle and stays while halt=1; drop halt with run=1 -> RUN.
REQ-036 Assert rst=0 during WAIT cycle 10 -> next cycle state=INIT, useqRST=1, nxm=0; late memACK after release ignored.
